// File: rtl/word_line_bridge.sv
// Single-line (BEATS x 64-bit) buffer between the core's 32-bit word port and
// the burst physical memory: read hits in one cycle, burst fill on miss, write-through.
module word_line_bridge #(
  parameter int unsigned BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam int unsigned LINE_W = 64 * BEATS;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
  localparam int unsigned WSEL_W = OFF_W - 2;
  localparam int unsigned TAG_W  = 32 - OFF_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITEBACK, S_RESPOND} state_t;

  state_t             r_state;
  logic               r_valid;
  logic [TAG_W-1:0]   r_tag;
  logic [CNT_W-1:0]   r_cnt;
  logic [LINE_W-1:0]  r_line;

  logic               w_hit;
  logic               w_last;
  logic               w_beat_ack;
  logic               w_do_merge;
  logic               w_line_we;
  logic [WSEL_W-1:0]  w_wsel;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [LINE_W-1:0]  w_base;
  logic [LINE_W-1:0]  w_merged;
  logic [LINE_W-1:0]  w_line_nxt;
  logic [31:0]        w_word_old;
  logic [31:0]        w_word_new;
  logic [31:0]        w_word_nxt;
  logic [31:0]        w_word_cur;
  logic [63:0]        w_wb_next;
  logic               w_unused;

  assign w_unused   = ^mem_address[1:0];
  assign w_hit      = r_valid && (r_tag == mem_address[31:OFF_W]);
  assign w_last     = (r_cnt == LAST_BEAT);
  assign w_beat_ack = (r_state == S_FILL) && pmem_resp;
  assign w_wsel     = mem_address[OFF_W-1:2];
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_wb_next  = r_line[int'(w_cnt_inc)*64 +: 64];
  assign w_word_cur = r_line[int'(w_wsel)*32 +: 32];

  // Next line image: arriving fill beat first, then the write merge on top of it.
  always_comb begin
    w_base = r_line;
    if (w_beat_ack) begin
      w_base[int'(r_cnt)*64 +: 64] = pmem_rdata;
    end
    w_word_old = w_base[int'(w_wsel)*32 +: 32];
    w_word_new = w_word_old;
    for (int k = 0; k < 4; k++) begin
      if (mem_byte_enable[k]) begin
        w_word_new[8*k +: 8] = mem_wdata[8*k +: 8];
      end
    end
    w_merged = w_base;
    w_merged[int'(w_wsel)*32 +: 32] = w_word_new;
    w_do_merge = mem_write &&
                 (((r_state == S_IDLE) && w_hit) || (w_beat_ack && w_last));
    w_line_nxt = w_do_merge ? w_merged : w_base;
    w_line_we  = w_do_merge || w_beat_ack;
    w_word_nxt = w_line_nxt[int'(w_wsel)*32 +: 32];
  end

  // Line data is deliberately not reset; validity is tracked by r_valid.
  always_ff @(posedge clk) begin
    if (w_line_we) begin
      r_line <= w_line_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_cnt        <= '0;
      mem_rdata    <= '0;
      mem_resp     <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // A write wins over a simultaneous read.
          if (mem_write) begin
            pmem_address <= {mem_address[31:OFF_W], OFF_W'(0)};
            if (w_hit) begin
              pmem_write <= 1'b1;
              pmem_wdata <= w_line_nxt[63:0];
              r_state    <= S_WRITEBACK;
            end else begin
              r_valid   <= 1'b0;
              pmem_read <= 1'b1;
              r_state   <= S_FILL;
            end
          end else if (mem_read) begin
            if (w_hit) begin
              mem_resp  <= 1'b1;
              mem_rdata <= w_word_nxt;
              r_state   <= S_RESPOND;
            end else begin
              pmem_address <= {mem_address[31:OFF_W], OFF_W'(0)};
              r_valid      <= 1'b0;
              pmem_read    <= 1'b1;
              r_state      <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (pmem_resp) begin
            r_cnt <= w_cnt_inc;
            if (w_last) begin
              pmem_read <= 1'b0;
              r_valid   <= 1'b1;
              r_tag     <= pmem_address[31:OFF_W];
              if (mem_write) begin
                pmem_write <= 1'b1;
                pmem_wdata <= w_line_nxt[63:0];
                r_state    <= S_WRITEBACK;
              end else begin
                mem_resp  <= 1'b1;
                mem_rdata <= w_word_nxt;
                r_state   <= S_RESPOND;
              end
            end
          end
        end
        S_WRITEBACK: begin
          if (pmem_resp) begin
            r_cnt      <= w_cnt_inc;
            pmem_wdata <= w_wb_next;
            if (w_last) begin
              pmem_write <= 1'b0;
              mem_resp   <= 1'b1;
              mem_rdata  <= w_word_cur;
              r_state    <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          mem_resp <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
